// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, D_BIT data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to add the parity_sel port and the PARITY state.
module uart_tx_cfg #(
  parameter int D_BIT   = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start,
  input  logic             s_tick,
  input  logic [D_BIT-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]       parity_sel,
`endif
  output logic             tx_busy,
  output logic             tx_done_tick,
  output logic             tx
);
  localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (D_BIT > 1) ? $clog2(D_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_reg, state_next;
  logic [S_W-1:0]   s_reg, s_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [D_BIT-1:0] shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  // Parity is resolved at acceptance, before the shift register consumes the data.
  logic             par_en_reg, par_en_next;
  logic             par_bit_reg, par_bit_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      n_reg       <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      n_reg       <= n_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    shift_next   = shift_reg;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          shift_next = din;
`ifdef UART_TX_PARITY_EN
          par_en_next  = (parity_sel == 2'b01) || (parity_sel == 2'b10);
          par_bit_next = (^din) ^ (parity_sel == 2'b10);
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_W'(OVS - 1)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_W'(OVS - 1)) begin
            s_next     = '0;
            shift_next = shift_reg >> 1;
            if (n_reg == N_W'(D_BIT - 1)) begin
              n_next     = '0;
`ifdef UART_TX_PARITY_EN
              state_next = par_en_reg ? PARITY : STOP;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_W'(OVS - 1)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_W'(SB_TICK - 1)) begin
            s_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line level follows the state being entered, so tx moves on the decision edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_bit_next;
`endif
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_done_tick = done_reg;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: tick-count frame model checked every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
  localparam int D_BIT = 8, OVS = 16, SB_TICK = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] tcnt = 2'd0;
  logic       s_tick;
  logic       tx_busy, tx_done_tick, tx;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_sel = 2'b00;
`endif

  int compared = 0;
  int mismatched = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign s_tick = (tcnt == 2'd3);

  uart_tx_cfg #(.D_BIT(D_BIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
`ifdef UART_TX_PARITY_EN
    .parity_sel(parity_sel),
`endif
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  // Model: a frame is a list of bit levels; the line shows bit (ticks_consumed / OVS).
  bit m_busy = 0, m_done = 0;
  int m_ticks = 0, m_total = 0, m_len = 0;
  bit m_bits[0:15];

  task automatic model_accept();
    int p;
    p = 0;
    m_bits[0] = 1'b0;
    for (int i = 0; i < D_BIT; i++) m_bits[1+i] = din[i];
`ifdef UART_TX_PARITY_EN
    if (parity_sel == 2'b01 || parity_sel == 2'b10) begin
      p = 1;
      m_bits[1+D_BIT] = (^din) ^ (parity_sel == 2'b10);
    end
`endif
    m_len   = 1 + D_BIT + p;
    m_total = m_len * OVS + SB_TICK;
    m_ticks = 0;
    m_busy  = 1;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_done = 0; m_ticks = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (s_tick) begin
          m_ticks++;
          if (m_ticks == m_total) begin m_busy = 0; m_done = 1; end
        end
      end else if (tx_start) begin
        model_accept();
      end
    end
  end

  function automatic bit m_tx();
    if (!m_busy) return 1'b1;
    if (m_ticks / OVS < m_len) return m_bits[m_ticks / OVS];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40) $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("tx", 32'(tx), 32'(m_tx()));
    check("busy", 32'(tx_busy), 32'(m_busy));
    check("done", 32'(tx_done_tick), 32'(m_done));
    if (tx_busy) busy_cnt++;
    if (tx_done_tick) done_cnt++;
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic send(input logic [7:0] d);
    do step(); while (!s_tick);
    din = d; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic capture(input int nbits, output logic [15:0] bits);
    int k;
    bits = '0;
    k = 0;
    while (tx !== 1'b0 && k < 4000) begin step(); k++; end
    if (k >= 4000) check("start_timeout", 32'(k), 32'd0);
    repeat (32) step();
    for (int i = 0; i < nbits; i++) begin
      bits[i] = tx;
      if (i != nbits - 1) repeat (64) step();
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (tx_done_tick !== 1'b1 && k < 2000) begin step(); k++; end
    if (k >= 2000) check("done_timeout", 32'(k), 32'd0);
  endtask

  logic [15:0] fb;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    // Idle after reset
    repeat (100) step();
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_done_cnt", 32'(done_cnt), 32'd0);

    // Plain 8N1 frame of 0xA5
    busy_cnt = 0; done_cnt = 0;
    send(8'hA5);
    capture(10, fb);
    check("a5_bits", 32'(fb), 32'h34A);
    wait_done(); repeat (5) step();
    check("a5_busy_len", 32'(busy_cnt), 32'd640);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);

`ifdef UART_TX_PARITY_EN
    parity_sel = 2'b01; busy_cnt = 0;
    send(8'hA5); capture(11, fb);
    check("even_bits", 32'(fb), 32'h54A);
    wait_done(); repeat (5) step();
    check("even_busy_len", 32'(busy_cnt), 32'd704);
    parity_sel = 2'b10; busy_cnt = 0;
    send(8'hA5); capture(11, fb);
    check("odd_bits", 32'(fb), 32'h74A);
    wait_done(); repeat (5) step();
    parity_sel = 2'b00; busy_cnt = 0;
    send(8'hA5); capture(10, fb);
    check("none_bits", 32'(fb), 32'h34A);
    wait_done(); repeat (5) step();
    check("none_busy_len", 32'(busy_cnt), 32'd640);
`endif

    // tx_start held through two frames
    done_cnt = 0;
    do step(); while (!s_tick);
    din = 8'h3C; tx_start = 1'b1;
    step();
    din = 8'hC3;
    capture(10, fb);
    check("b2b_first_bits", 32'(fb), 32'h278);
    wait_done();
    check("b2b_done_tx", 32'(tx), 32'd1);
    step();
    check("b2b_gap_tx", 32'(tx), 32'd0);
    check("b2b_gap_busy", 32'(tx_busy), 32'd1);
    tx_start = 1'b0;
    capture(10, fb);
    check("b2b_second_bits", 32'(fb), 32'h386);
    wait_done(); repeat (200) step();
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // din and tx_start activity while busy
    busy_cnt = 0; done_cnt = 0;
    send(8'h5A);
    fork
      capture(10, fb);
      begin
        repeat (200) step();
        din = 8'hFF; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
      end
    join
    check("busy_ign_bits", 32'(fb), 32'h2B4);
    wait_done(); repeat (100) step();
    check("busy_ign_len", 32'(busy_cnt), 32'd640);
    check("busy_ign_done", 32'(done_cnt), 32'd1);

    // Reset in the middle of data bit 3
    done_cnt = 0;
    send(8'hA5);
    repeat (287) step();
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (200) step();
    check("rst_no_done", 32'(done_cnt), 32'd0);
    send(8'h96);
    capture(10, fb);
    check("post_rst_bits", 32'(fb), 32'h32C);
    wait_done(); repeat (5) step();
    check("post_rst_done", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
